// File: rtl/gs_pkg.sv
// Shared types and constants for the RGB-to-grayscale block.
package gs_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_R = 3'd1,
        GET_G = 3'd2,
        GET_B = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } gs_state_e;

    localparam int unsigned W_R_DEF    = 77;
    localparam int unsigned W_G_DEF    = 150;
    localparam int unsigned W_B_DEF    = 29;
    localparam int unsigned ROUND      = 128;
    localparam int unsigned WEIGHT_SUM = 256;

endpackage

// File: rtl/gs_weighted_sum.sv
// Combinational luma multiply-add: W_R*r + W_G*g + W_B*b + rounding constant.
module gs_weighted_sum
    import gs_pkg::*;
#(
    parameter int unsigned W_R = W_R_DEF,
    parameter int unsigned W_G = W_G_DEF,
    parameter int unsigned W_B = W_B_DEF
) (
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [15:0] sum
);

    logic [15:0] prod_r;
    logic [15:0] prod_g;
    logic [15:0] prod_b;

    // Weights sum to 256, so the total never exceeds 65408 and fits in 16 bits.
    always_comb begin
        prod_r = 16'(W_R) * {8'h00, r};
        prod_g = 16'(W_G) * {8'h00, g};
        prod_b = 16'(W_B) * {8'h00, b};
        sum    = prod_r + prod_g + prod_b + 16'(ROUND);
    end

endmodule

// File: rtl/rgb_grayscaler.sv
// Serial R,G,B byte stream to one luma byte per pixel, with a frame-done pulse
// after N*M pixels.
module rgb_grayscaler
    import gs_pkg::*;
#(
    parameter int unsigned N   = 2,
    parameter int unsigned M   = 2,
    parameter int unsigned W_R = W_R_DEF,
    parameter int unsigned W_G = W_G_DEF,
    parameter int unsigned W_B = W_B_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       GS_enable,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       in_ready,
    output logic [7:0] gs_data,
    output logic       GS_valid,
    output logic       GS_done
);

    localparam int unsigned NUM_PIX = N * M;
    localparam int unsigned CNT_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);

    if (W_R + W_G + W_B != WEIGHT_SUM) begin : g_weight_check
        $error("rgb_grayscaler: W_R + W_G + W_B must equal 256");
    end

    gs_state_e        state;
    logic [CNT_W-1:0] pix_cnt;
    logic [7:0]       r_lat;
    logic [7:0]       g_lat;
    logic [15:0]      acc;
    logic [15:0]      sum;
    logic             unused_acc_lsb;

    gs_weighted_sum #(
        .W_R (W_R),
        .W_G (W_G),
        .W_B (W_B)
    ) u_weighted_sum (
        .r   (r_lat),
        .g   (g_lat),
        .b   (pix_data),
        .sum (sum)
    );

    assign in_ready       = (state == GET_R) || (state == GET_G) || (state == GET_B);
    assign gs_data        = acc[15:8];
    assign unused_acc_lsb = ^acc[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            r_lat    <= 8'h00;
            g_lat    <= 8'h00;
            acc      <= 16'h0000;
            GS_valid <= 1'b0;
            GS_done  <= 1'b0;
        end else begin
            GS_valid <= 1'b0;
            GS_done  <= 1'b0;
            // Abort wins over everything; a strobe already registered for EMIT still shows.
            if (state != IDLE && !GS_enable) begin
                state   <= IDLE;
                pix_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        pix_cnt <= '0;
                        if (GS_enable) state <= GET_R;
                    end
                    GET_R: begin
                        if (pix_valid) begin
                            r_lat <= pix_data;
                            state <= GET_G;
                        end
                    end
                    GET_G: begin
                        if (pix_valid) begin
                            g_lat <= pix_data;
                            state <= GET_B;
                        end
                    end
                    GET_B: begin
                        if (pix_valid) begin
                            acc      <= sum;
                            GS_valid <= 1'b1;
                            state    <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (pix_cnt == LAST_PIX) begin
                            GS_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                            state   <= GET_R;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_grayscaler.sv
// Self-checking bench for rgb_grayscaler: vector table, corner sequences and random frames.
module tb_rgb_grayscaler;

    logic       clk;
    logic       rst_n;
    logic       GS_enable;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       in_ready;
    logic [7:0] gs_data;
    logic       GS_valid;
    logic       GS_done;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         gap_b;
        int         exp;
    } vec_t;

    vec_t vecs [8];

    rgb_grayscaler #(
        .N   (2),
        .M   (2),
        .W_R (77),
        .W_G (150),
        .W_B (29)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .GS_enable (GS_enable),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .in_ready  (in_ready),
        .gs_data   (gs_data),
        .GS_valid  (GS_valid),
        .GS_done   (GS_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference luma from the plain formula.
    function automatic int ref_gray(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b + 128) / 256;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (GS_valid) begin
                valid_cnt++;
                check("ready_low_during_strobe", in_ready, 0);
            end
            if (GS_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        k = 0;
        pix_valid = 1'b0;
        repeat (gap) tick();
        pix_data  = b;
        pix_valid = 1'b1;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) check("ready_timeout", in_ready, 1);
        tick();
        pix_valid = 1'b0;
        pix_data  = 8'hA5;
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input int gap_r, input int gap_b, input string name,
                              input int exp);
        send_byte(r, gap_r);
        send_byte(g, 0);
        send_byte(b, gap_b);
        check({name, "_valid"}, GS_valid, 1);
        check({name, "_ready"}, in_ready, 0);
        check({name, "_data"}, gs_data, exp);
    endtask

    task automatic expect_done(input string name);
        check({name, "_done_early"}, GS_done, 0);
        tick();
        check({name, "_done"}, GS_done, 1);
        check({name, "_valid_in_done"}, GS_valid, 0);
        tick();
        check({name, "_done_one_cycle"}, GS_done, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int d0;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;

        vecs[0] = '{8'd255, 8'd255, 8'd255, 0, 255};
        vecs[1] = '{8'd100, 8'd50,  8'd200, 0, 82};
        vecs[2] = '{8'd255, 8'd0,   8'd0,   0, 77};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   0, 0};
        vecs[4] = '{8'd10,  8'd20,  8'd30,  0, 18};
        vecs[5] = '{8'd0,   8'd0,   8'd255, 3, 29};
        vecs[6] = '{8'd0,   8'd255, 8'd0,   0, 149};
        vecs[7] = '{8'd255, 8'd0,   8'd0,   0, 77};

        rst_n     = 1'b0;
        GS_enable = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        #1;
        check("rst_gs_data", gs_data, 0);
        check("rst_valid", GS_valid, 0);
        check("rst_done", GS_done, 0);
        check("rst_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_ready", in_ready, 0);

        // Two table frames; the second has a 3-cycle gap before B.
        GS_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_pixel(vecs[i].r, vecs[i].g, vecs[i].b, 0, vecs[i].gap_b,
                       $sformatf("vec%0d", i), vecs[i].exp);
            if (i % 4 == 3) expect_done($sformatf("frame%0d", i / 4));
        end
        check("table_valid_count", valid_cnt, 8);
        check("table_done_count", done_cnt, 2);

        // Abort after the second byte of pixel 2.
        send_pixel(8'd255, 8'd255, 8'd255, 0, 0, "abort_p1", 255);
        send_byte(8'd40, 0);
        send_byte(8'd60, 0);
        GS_enable = 1'b0;
        v0 = valid_cnt;
        d0 = done_cnt;
        repeat (6) tick();
        check("abort_ready", in_ready, 0);
        check("abort_no_valid", valid_cnt, v0);
        check("abort_no_done", done_cnt, d0);
        check("abort_data_held", gs_data, 255);

        GS_enable = 1'b1;
        for (int p = 0; p < 4; p++) begin
            r = 8'($urandom_range(0, 255));
            g = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            send_pixel(r, g, b, 0, 0, $sformatf("reen_p%0d", p), ref_gray(r, g, b));
        end
        expect_done("reen");
        check("reen_valid_count", valid_cnt - v0, 4);
        check("reen_done_count", done_cnt - d0, 1);

        // Enable dropped during EMIT of the last pixel: strobe stays, no done.
        for (int p = 0; p < 4; p++)
            send_pixel(8'd1, 8'd2, 8'd3, 0, 0, $sformatf("emit_abort_p%0d", p), 2);
        GS_enable = 1'b0;
        d0 = done_cnt;
        repeat (3) tick();
        check("emit_abort_no_done", done_cnt, d0);
        check("emit_abort_ready", in_ready, 0);

        // Asynchronous reset while waiting for G.
        GS_enable = 1'b1;
        send_pixel(8'd200, 8'd200, 8'd200, 0, 0, "pre_rst", ref_gray(200, 200, 200));
        send_byte(8'd9, 0);
        check("pre_rst_ready", in_ready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_gs_data", gs_data, 0);
        check("async_rst_ready", in_ready, 0);
        check("async_rst_valid", GS_valid, 0);
        check("async_rst_done", GS_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_pixel(8'd1, 8'd2, 8'd3, 0, 0, "post_rst", 2);
        for (int p = 1; p < 4; p++)
            send_pixel(8'd0, 8'd0, 8'd0, 0, 0, $sformatf("post_rst_p%0d", p), 0);
        expect_done("post_rst");

        // Random frames with random byte gaps.
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < 4; p++) begin
                r = 8'($urandom_range(0, 255));
                g = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                send_pixel(r, g, b, $urandom_range(0, 2), $urandom_range(0, 2),
                           $sformatf("rand_f%0d_p%0d", f, p), ref_gray(r, g, b));
            end
            expect_done($sformatf("rand_f%0d", f));
        end

        GS_enable = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_grayscaler.md
Name: rgb_grayscaler

Overview:
- Upstream neighbour of the R/W pixel memory. Consumes the camera's serial RGB byte stream in the order R, G, B.
- For each pixel it produces one 8-bit luma byte, gray = (77·R + 150·G + 29·B + 128) >> 8.
- It presents that byte on gs_data with a one-cycle GS_valid strobe, which is the memory's write qualifier. It signals frame completion to the controller after N·M pixels.

Parameters:
- N, 2, image height in pixels.
- M, 2, image width in pixels.
- W_R, 77, red weight (8-bit unsigned).
- W_G, 150, green weight (8-bit unsigned).
- W_B, 29, blue weight (8-bit unsigned). W_R+W_G+W_B must equal 256 (elaboration check).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- GS_enable  in  1  controller enable; level-sensitive; low aborts any frame in progress.
- pix_valid  in  1  camera byte qualifier.
- pix_data  in  8  camera byte (R, G, B sequence).
- in_ready  out  1  block can accept a byte this cycle.
- gs_data  out  8  gray byte; holds last value between strobes.
- GS_valid  out  1  one-cycle strobe, gs_data valid.
- GS_done  out  1  one-cycle pulse, frame of N·M pixels complete.

Behaviour:
- Reset, asynchronous:
  - State IDLE; gs_data=8'h00; GS_valid=0; GS_done=0; in_ready=0.
  - Pixel counter=0; R/G latches=0; accumulator=0.
- Byte transfer occurs when pix_valid && in_ready at the clock edge. in_ready=1 only in GET_R, GET_G and GET_B.
- States:
  - IDLE:
    - in_ready=0.
    - Go to GET_R when GS_enable=1.
    - The pixel counter clears on entry.
  - GET_R:
    - On transfer, latch R and go to GET_G.
  - GET_G:
    - On transfer, latch G and go to GET_B.
  - GET_B:
    - On transfer, register sum = W_R·R + W_G·G + W_B·B + 128 into a 16-bit accumulator.
    - Go to EMIT.
  - EMIT (1 cycle):
    - gs_data <= sum[15:8]; GS_valid=1 for exactly this cycle; in_ready=0.
    - If pixel counter == N·M-1: go to DONE. Otherwise increment the counter and go to GET_R.
  - DONE (1 cycle):
    - GS_done=1, GS_valid=0.
    - Go to IDLE. A new frame starts only if GS_enable is still or again high in IDLE.
- Latency: GS_valid is asserted in the cycle after the B transfer edge, i.e. 1 clock. Minimum throughput is 4 cycles per pixel.
- Registered outputs: GS_valid, GS_done and gs_data are driven from state registers, with no combinational path from pix_*.
- Arithmetic:
  - Products are 16-bit unsigned.
  - Maximum sum is 255·256+128 = 65408, so there is no overflow and sum[15:8] ≤ 255. No saturation logic is needed.
- pix_valid low: the FSM waits in its GET_x state indefinitely; latched bytes are preserved.
- GS_enable deasserted in any state other than IDLE:
  - Return to IDLE next cycle; discard partial pixel; counter cleared.
  - No GS_valid or GS_done is issued. gs_data retains its last value.
- GS_enable deasserted during EMIT: the strobe for that cycle still occurs (already registered), then the block goes to IDLE.
- Bytes presented while in_ready=0 are ignored, not buffered. The camera must honour in_ready.
- Wrap-around: the counter spans 0..N·M-1 and is sized as $clog2(N·M), minimum 1 bit. Frame end is detected by compare, not overflow.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.

Decomposition:
- Package gs_pkg holds:
  - State encoding localparams: IDLE, GET_R, GET_G, GET_B, EMIT, DONE (3-bit).
  - Default weights and the rounding constant 128.
  - The weight-sum check constant 256.
- Sub-module gs_weighted_sum: purely combinational 3×8-bit multiply-add plus rounding constant, producing the 16-bit sum. It is registered by the parent, which keeps the FSM separate from the datapath.

Test Plan:
- Pixel (255,255,255) with continuous pix_valid → GS_valid one cycle after the B edge, gs_data=255, in_ready low during EMIT.
- Pixel (100,50,200) → sum 21128, gs_data=82; pixel (255,0,0) → gs_data=77; pixel (0,0,0) → gs_data=0.
- Full 2×2 frame of pixels (10,20,30), (0,0,255), (0,255,0), (255,0,0):
  - gs_data sequence 18, 29, 149, 77, each with one GS_valid.
  - GS_done one cycle after the fourth strobe; no GS_done earlier.
- pix_valid gaps of 3 idle cycles between G and B → FSM holds GET_B, latched R/G intact, result identical to gapless run.
- GS_enable dropped after the second byte of pixel 2 → no further GS_valid, no GS_done. After re-enable, the next complete frame yields exactly 4 strobes plus GS_done.
- rst_n asserted asynchronously mid-GET_G → all outputs 0 immediately. After release, the first pixel (1,2,3) yields gs_data=2.
